regfile_wr_ctrl: RTL and testbench

Write-port controller for the team's parameterised register file (one write port: `wen1`/`ad1`/`din1`, written on the falling edge of `clk`; two combinational read ports). It has two jobs:
- After reset, or on a clear request, it sequences a full zero-fill of the array, because the register file has no reset of its own.
- In normal operation it shares the single write port among `N_REQ` requesters with round-robin arbitration and valid/ready handshakes.

It sits directly in front of the register file and drives all three write-port inputs.

---
 rtl/regfile_ctrl_pkg.sv | 23 ++
 rtl/regfile_wr_ctrl_rr_arbiter.sv | 36 +++
 rtl/regfile_wr_ctrl.sv | 135 +++++++++++++
 tb/tb_regfile_wr_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_ctrl_pkg.sv
// Shared types and request-packing helpers for the register-file write-port controller.
package regfile_ctrl_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } ctrl_state_t;

    localparam int unsigned DEF_ADDR_WIDTH = 4;
    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_N_REQ      = 4;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // LSB of requester idx's field inside a flattened request bus.
    function automatic int unsigned field_lsb(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/regfile_wr_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping.
module rr_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned IW    = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    gnt_idx,
    output logic             any
);

    int unsigned idx;

    // Walk from ptr upward; the first hit is latched by the any flag.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/regfile_wr_ctrl.sv
// Register-file write-port controller: zero-fills the array after reset/clear,
// then shares the single write port among N_REQ requesters round-robin.
module regfile_wr_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned N_REQ      = DEF_N_REQ
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]              req_ready,
    output logic                          wen1,
    output logic [ADDR_WIDTH-1:0]         ad1,
    output logic [DATA_WIDTH-1:0]         din1,
    output logic                          init_done
);

    localparam int unsigned IW = idx_width(N_REQ);

    ctrl_state_t           state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q,   cnt_d;
    logic [IW-1:0]         ptr_q,   ptr_d;
    logic                  wen_q,   wen_d;
    logic [ADDR_WIDTH-1:0] ad_q,    ad_d;
    logic [DATA_WIDTH-1:0] din_q,   din_d;
    logic                  done_q,  done_d;

    logic [ADDR_WIDTH-1:0] addr_arr [N_REQ];
    logic [DATA_WIDTH-1:0] data_arr [N_REQ];

    logic [N_REQ-1:0] gnt;
    logic [IW-1:0]    gnt_idx;
    logic             gnt_any;
    logic             arb_en;
    logic             accept;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign addr_arr[i] = req_addr[field_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH];
        assign data_arr[i] = req_data[field_lsb(i, DATA_WIDTH) +: DATA_WIDTH];
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (gnt_any)
    );

    // Grants are only visible in RUN and are withheld while a clear is requested.
    always_comb begin
        arb_en    = (state_q == RUN) && !clr;
        req_ready = arb_en ? gnt : '0;
        accept    = arb_en && gnt_any;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        wen_d   = wen_q;
        ad_d    = ad_q;
        din_d   = din_q;
        done_d  = done_q;
        unique case (state_q)
            CLEAR: begin
                if (clr) begin
                    cnt_d = '0;
                    wen_d = 1'b0;
                end else begin
                    wen_d = 1'b1;
                    ad_d  = cnt_q;
                    din_d = '0;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    wen_d   = 1'b0;
                end else if (accept) begin
                    wen_d = 1'b1;
                    ad_d  = addr_arr[gnt_idx];
                    din_d = data_arr[gnt_idx];
                    ptr_d = (32'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
                end else begin
                    wen_d = 1'b0;
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            ptr_q   <= '0;
            wen_q   <= 1'b0;
            ad_q    <= '0;
            din_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            wen_q   <= wen_d;
            ad_q    <= ad_d;
            din_q   <= din_d;
            done_q  <= done_d;
        end
    end

    assign wen1      = wen_q;
    assign ad1       = ad_q;
    assign din1      = din_q;
    assign init_done = done_q;

endmodule

// File: tb/tb_regfile_wr_ctrl.sv
// Bench for regfile_wr_ctrl: directed fill/clear/reset steps plus random traffic
// against a priority-distance arbitration model and an expected-memory image.
module tb_regfile_wr_ctrl;

    logic        clk;
    logic        rst;
    logic        clr;
    logic [3:0]  req_valid;
    logic [15:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        wen1;
    logic [3:0]  ad1;
    logic [7:0]  din1;
    logic        init_done;

    regfile_wr_ctrl #(
        .ADDR_WIDTH (4),
        .DATA_WIDTH (8),
        .N_REQ      (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wen1      (wen1),
        .ad1       (ad1),
        .din1      (din1),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register file written on the falling edge.
    logic [7:0] rf [16];
    logic       preload;
    always @(negedge clk) begin
        if (preload) begin
            for (int k = 0; k < 16; k++) rf[k] <= 8'h5A + 8'(k);
        end else if (wen1) begin
            rf[ad1] <= din1;
        end
    end

    int         n_chk  = 0;
    int         n_fail = 0;
    int         m_ptr  = 0;
    logic [3:0] m_ad   = '0;
    logic [7:0] m_din  = '0;
    logic [7:0] exp_mem [16];
    logic [3:0] ra [4];
    logic [7:0] rd [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One bus cycle: expected grant is the valid requester nearest after m_ptr.
    task automatic cycle(input logic [3:0] v, output int g);
        int bestd, d;
        req_valid = v;
        for (int i = 0; i < 4; i++) begin
            req_addr[i*4 +: 4] = ra[i];
            req_data[i*8 +: 8] = rd[i];
        end
        #1;
        g = -1;
        bestd = 99;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) begin
                d = (i - m_ptr + 4) % 4;
                if (d < bestd) begin
                    bestd = d;
                    g = i;
                end
            end
        end
        chk("ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
        @(posedge clk); #1;
        if (g >= 0) begin
            m_ad  = ra[g];
            m_din = rd[g];
            exp_mem[ra[g]] = rd[g];
            m_ptr = (g + 1) % 4;
        end
        chk("wen1", 32'(wen1), (g >= 0) ? 32'd1 : 32'd0);
        chk("ad1", 32'(ad1), 32'(m_ad));
        chk("din1", 32'(din1), 32'(m_din));
    endtask

    task automatic fill_chk(input int last);
        for (int i = 0; i <= last; i++) begin
            chk("fill_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
            chk("fill_wen", 32'(wen1), 32'd1);
            chk("fill_ad", 32'(ad1), 32'(i));
            chk("fill_din", 32'(din1), 32'd0);
            chk("fill_done", 32'(init_done), (i == 15) ? 32'd1 : 32'd0);
        end
        if (last == 15) begin
            m_ad  = 4'hF;
            m_din = '0;
            for (int k = 0; k < 16; k++) exp_mem[k] = '0;
        end
    endtask

    task automatic mem_chk();
        @(negedge clk); #1;
        for (int k = 0; k < 16; k++) chk("mem", 32'(rf[k]), 32'(exp_mem[k]));
    endtask

    initial begin
        int         g;
        logic [3:0] pend;
        logic [3:0] order5 [5];
        rst = 1'b1; clr = 1'b0; req_valid = 4'hF; req_addr = '0; req_data = '0;
        preload = 1'b1;
        for (int i = 0; i < 4; i++) begin ra[i] = '0; rd[i] = '0; end
        repeat (2) @(posedge clk);
        #1;
        preload = 1'b0;
        chk("rst_wen", 32'(wen1), 32'd0);
        chk("rst_ad", 32'(ad1), 32'd0);
        chk("rst_din", 32'(din1), 32'd0);
        chk("rst_done", 32'(init_done), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("preload", 32'(rf[3]), 32'h5D);

        // Reset fill
        rst = 1'b0; req_valid = '0;
        #1;
        chk("cyc1_wen", 32'(wen1), 32'd0);
        fill_chk(15);
        mem_chk();

        // Single write from requester 2 with no-bypass read check
        ra[2] = 4'd5; rd[2] = 8'hA5;
        cycle(4'b0100, g);
        chk("nobypass", 32'(rf[5]), 32'd0);
        mem_chk();
        cycle(4'b0000, g);

        // Bring ptr back to 0, then full contention
        ra[3] = 4'd14; rd[3] = 8'h33;
        cycle(4'b1000, g);
        for (int i = 0; i < 4; i++) begin ra[i] = 4'(10 + i); rd[i] = 8'h80 + 8'(i); end
        order5[0] = 4'b0001; order5[1] = 4'b0010; order5[2] = 4'b0100;
        order5[3] = 4'b1000; order5[4] = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            #1;
            req_valid = 4'hF;
            for (int i = 0; i < 4; i++) begin
                req_addr[i*4 +: 4] = ra[i];
                req_data[i*8 +: 8] = rd[i];
            end
            #1;
            chk("contend_order", 32'(req_ready), 32'(order5[k]));
            cycle(4'hF, g);
            if (g >= 0) rd[g] = rd[g] + 8'h10;
        end
        mem_chk();

        // Sparse round-robin from ptr 0: grants 1, 3, 1
        ra[3] = 4'd2; rd[3] = 8'h44;
        cycle(4'b1000, g);
        cycle(4'b0000, g);
        ra[1] = 4'd7; rd[1] = 8'h71; ra[3] = 4'd8; rd[3] = 8'h83;
        cycle(4'b1010, g);
        chk("sparse_first", 32'(ad1), 32'd7);
        rd[1] = 8'h72;
        cycle(4'b1010, g);
        chk("sparse_second", 32'(ad1), 32'd8);
        rd[3] = 8'h84;
        cycle(4'b1010, g);
        chk("sparse_third", 32'(ad1), 32'd7);
        cycle(4'b0000, g);
        mem_chk();

        // Clear under load
        ra[0] = 4'd9; rd[0] = 8'h3C;
        req_valid = 4'b0001;
        req_addr[3:0] = ra[0];
        req_data[7:0] = rd[0];
        clr = 1'b1;
        #1;
        chk("clr_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        clr = 1'b0;
        chk("clr_wen", 32'(wen1), 32'd0);
        chk("clr_done", 32'(init_done), 32'd0);
        fill_chk(15);
        cycle(4'b0001, g);
        chk("clr_grant_addr", 32'(ad1), 32'd9);
        cycle(4'b0000, g);
        mem_chk();

        // Reset mid-fill
        clr = 1'b1;
        #1;
        @(posedge clk); #1;
        clr = 1'b0;
        fill_chk(7);
        chk("midfill_ad7", 32'(ad1), 32'd7);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_ptr = 0;
        chk("midrst_wen", 32'(wen1), 32'd0);
        chk("midrst_done", 32'(init_done), 32'd0);
        chk("midrst_ad", 32'(ad1), 32'd0);
        fill_chk(15);
        mem_chk();

        // Random traffic with hold-until-accepted requesters
        pend = '0;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i] = 1'b1;
                    ra[i] = 4'($urandom_range(0, 15));
                    rd[i] = 8'($urandom);
                end
            end
            cycle(pend, g);
            if (g >= 0) pend[g] = 1'b0;
        end
        cycle(4'b0000, g);
        mem_chk();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
